// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART byte-to-command controller.
package uart_cmd_pkg;

  // Controller states: waiting for high byte, waiting for low byte, command pending.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    VALID   = 2'd2
  } cmd_state_t;

  // UART bit period in clk cycles and frame length (start + 8 data + stop).
  localparam int BAUD_DIV      = 2604;
  localparam int BITS_PER_BYTE = 10;

  // Inter-byte window: two byte times (2 * 10 * 2604 = 52080 cycles).
  localparam int DEF_TIMEOUT   = 2 * BITS_PER_BYTE * BAUD_DIV;

endpackage : uart_cmd_pkg

// File: rtl/uart_cmd_timer.sv
// Inter-byte timer: synchronous clear, count enable, terminal-count flag.
// The count saturates at TIMEOUT_CYCLES-1, so it never wraps.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 52080,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next count: clear wins over enable, and counting stops at the terminal value.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !last_o) begin
      count_d = count_q + TO_W'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == LAST_CNT);

endmodule : uart_cmd_timer

// File: rtl/uart_cmd_ctrl.sv
// Byte-to-command controller: pairs two received bytes (high first) into a
// 16-bit command with a cmd_rdy/clr_cmd_rdy handshake, discards an orphaned
// high byte after an inter-byte timeout, and flags bytes dropped while a
// command is still pending.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        rx_clr_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        timeout_err,
  output logic        overrun_err
);

  cmd_state_t  state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        timeout_q, timeout_d;
  logic        overrun_q, overrun_d;

  logic        accept;
  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_last;

  // A byte is consumed in any state, but never while reset is held.
  assign accept = rx_rdy & ~rst;

  uart_cmd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .last_o (tmr_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decisions for each byte/ack/timeout event.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hi_d    = rx_data;
          tmr_clr = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A low byte in the terminal timer cycle still completes the command.
        if (accept) begin
          cmd_d   = {hi_q, rx_data};
          state_d = VALID;
        end else if (tmr_last) begin
          timeout_d = 1'b1;
          hi_d      = '0;
          state_d   = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      VALID: begin
        if (clr_cmd_rdy) begin
          // A byte arriving with the acknowledge starts the next command.
          if (accept) begin
            hi_d    = rx_data;
            tmr_clr = 1'b1;
            state_d = WAIT_LO;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      cmd_q     <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs: cmd_rdy is exactly "a command is pending".
  always_comb begin
    rx_clr_rdy  = accept;
    cmd         = cmd_q;
    cmd_rdy     = (state_q == VALID);
    timeout_err = timeout_q;
    overrun_err = overrun_q;
  end

endmodule : uart_cmd_ctrl
